bellman_sched: RTL

- Sequencer and owner of the adjacency-matrix write port for the Bellman relaxation engine.
- Buffers incoming edge-weight updates (row, col, weight) in a small FIFO.
- Commits buffered updates to adjmat only while Bellman is held in reset.
- Launches a Bellman run whenever the graph changed or a run is requested, waits for bellman_done, then reports completion to the host side.

---
 rtl/bellman_pkg.sv | 22 ++
 rtl/bellman_sched_fifo.sv | 75 +++++++
 rtl/bellman_sched.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bellman_pkg.sv
// Shared types for the Bellman relaxation scheduler.
// Edge-update bundle and scheduler state encoding.
package bellman_pkg;

    localparam int NODES    = 8;
    localparam int PRED_W   = 3;
    localparam int WEIGHT_W = 32;

    typedef struct packed {
        logic [PRED_W-1:0]          row;
        logic [PRED_W-1:0]          col;
        logic signed [WEIGHT_W-1:0] weight;
    } edge_upd_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        RUN,
        REPORT
    } sched_state_t;

endpackage

// File: rtl/bellman_sched_fifo.sv
// Small synchronous FIFO buffering edge-weight updates.
// Pointers wrap modulo DEPTH; count is one bit wider to tell full from empty.
module upd_fifo
    import bellman_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  edge_upd_t   din,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output edge_upd_t   head
);

    edge_upd_t     mem_q [DEPTH];
    edge_upd_t     mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next storage, pointer and occupancy values
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset discards all contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bellman_sched.sv
// Sequencer owning the adjmat write port and the Bellman run handshake.
// Optional RUN watchdog with timeout port: define BELLMAN_SCHED_TIMEOUT_EN.
module bellman_sched #(
    parameter int NODES      = 8,
    parameter int PRED_W     = 3,
    parameter int WEIGHT_W   = 32,
    parameter int FIFO_DEPTH = 4
`ifdef BELLMAN_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [PRED_W-1:0]   upd_row,
    input  logic [PRED_W-1:0]   upd_col,
    input  logic [WEIGHT_W-1:0] upd_weight,
    input  logic                run_req,
    output logic                bellman_reset,
    input  logic                bellman_done,
    output logic                adjmat_we,
    output logic [PRED_W-1:0]   adjmat_wr_row,
    output logic [PRED_W-1:0]   adjmat_wr_col,
    output logic [WEIGHT_W-1:0] adjmat_wr_data,
    output logic                busy,
    output logic                result_valid,
    output logic [15:0]         run_count
`ifdef BELLMAN_SCHED_TIMEOUT_EN
    ,
    output logic                timeout
`endif
);

    import bellman_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);

    sched_state_t state_q;
    sched_state_t state_d;

    edge_upd_t   upd_in;
    edge_upd_t   fifo_head;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_count;

    logic        dirty_q;
    logic        dirty_d;
    logic        we_q;
    logic        we_d;
    edge_upd_t   wr_q;
    edge_upd_t   wr_d;
    logic [15:0] run_count_q;
    logic [15:0] run_count_d;

`ifdef BELLMAN_SCHED_TIMEOUT_EN
    logic [31:0] wd_q;
    logic [31:0] wd_d;
    logic        timeout_q;
    logic        timeout_d;
    logic        wd_hit;

    assign wd_hit  = (wd_q == 32'(TIMEOUT_CYCLES - 1));
    assign timeout = timeout_q;
`endif

    assign upd_in    = '{row: upd_row, col: upd_col, weight: upd_weight};
    assign upd_ready = (fifo_count != (AW+1)'(FIFO_DEPTH));
    assign fifo_push = upd_valid && !fifo_full;

    upd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (upd_in),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count),
        .head (fifo_head)
    );

    // Scheduler state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: pending updates drain before any run may start
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = DRAIN;
                end else if (dirty_q || run_req) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !we_q) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bellman_done) begin
                    state_d = REPORT;
                end
`ifdef BELLMAN_SCHED_TIMEOUT_EN
                else if (wd_hit) begin
                    state_d = REPORT;
                end
`endif
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath controls: FIFO pop, adjmat write register, dirty, counters
    always_comb begin
        fifo_pop    = 1'b0;
        we_d        = 1'b0;
        wr_d        = wr_q;
        dirty_d     = dirty_q;
        run_count_d = run_count_q;
`ifdef BELLMAN_SCHED_TIMEOUT_EN
        wd_d        = '0;
        timeout_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (state_d == RUN) begin
                    dirty_d = 1'b0;
                end
            end
            DRAIN: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    we_d     = 1'b1;
                    wr_d     = fifo_head;
                    dirty_d  = 1'b1;
                end
            end
            RUN: begin
`ifdef BELLMAN_SCHED_TIMEOUT_EN
                wd_d = wd_q + 32'd1;
                if (!bellman_done && wd_hit) begin
                    timeout_d = 1'b1;
                    dirty_d   = 1'b1;
                end
`endif
                if (state_d == REPORT) begin
                    run_count_d = run_count_q + 16'd1;
                end
            end
            REPORT: begin
                dirty_d = dirty_q;
            end
            default: begin
                dirty_d = dirty_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty_q     <= 1'b0;
            we_q        <= 1'b0;
            wr_q        <= '0;
            run_count_q <= '0;
`ifdef BELLMAN_SCHED_TIMEOUT_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            dirty_q     <= dirty_d;
            we_q        <= we_d;
            wr_q        <= wr_d;
            run_count_q <= run_count_d;
`ifdef BELLMAN_SCHED_TIMEOUT_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        bellman_reset  = (state_q != RUN);
        busy           = (state_q != IDLE);
        result_valid   = (state_q == REPORT);
        adjmat_we      = we_q;
        adjmat_wr_row  = wr_q.row;
        adjmat_wr_col  = wr_q.col;
        adjmat_wr_data = wr_q.weight;
        run_count      = run_count_q;
    end

    // Accepted updates must address an existing vertex
    assert property (@(posedge clk) disable iff (reset)
        (upd_valid && upd_ready) |-> (int'(upd_row) < NODES && int'(upd_col) < NODES));

endmodule
